// File: rtl/lab3_pattern_gen_pkg.sv
// Shared constants for the lab3 pattern generator: advance-mode encodings,
// ping-pong direction and the default LFSR feedback mask for an 8-bit pattern.
package lab3_pattern_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD     = 3'd0,
      MODE_TOGGLE   = 3'd1,
      MODE_ROTL     = 3'd2,
      MODE_ROTR     = 3'd3,
      MODE_LFSR     = 3'd4,
      MODE_COUNT    = 3'd5,
      MODE_PINGPONG = 3'd6,
      MODE_RSVD     = 3'd7
   } mode_t;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_t;

   // x^8+x^4+x^3+x^2+1 when feedback enters at bit 0: maximal length 255
   localparam logic [7:0] DEFAULT_TAPS = 8'hB8;
   localparam logic [7:0] DEFAULT_INIT = 8'b0101_0101;

endpackage

// File: rtl/lab3_pattern_gen_step_div.sv
// Step divider: counts enabled cycles and flags an advance every step_div+1.
// A mid-count drop of step_div below the count simply runs the counter round.
module lab3_step_div #(
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [DIV_W-1:0] step_div,
   output logic             adv
);

   logic [DIV_W-1:0] div_cnt;
   logic             match;

   assign match = (div_cnt == step_div);
   assign adv   = en && !clr && match;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (clr) begin
         div_cnt <= '0;
      end else if (en) begin
         if (match) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/lab3_pattern_gen.sv
// Register-based pattern generator: q advances by the selected mode every
// step_div+1 enabled cycles; load reseeds, wrap flags a return to the seed.
//
// dir state | meaning
// ----------+------------------------------------------------
// DIR_LEFT  | ping-pong shifts toward the MSB (reset/load)
// DIR_RIGHT | ping-pong shifts toward the LSB
module lab3_pattern_gen
   import lab3_pattern_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] INIT  = WIDTH'(DEFAULT_INIT),
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
   parameter int               DIV_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic [2:0]       mode,
   input  logic [DIV_W-1:0] step_div,
   output logic [WIDTH-1:0] q,
   output logic             step,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] seed;
   logic [WIDTH-1:0] q_nxt;
   dir_t             dir;
   dir_t             dir_nxt;
   logic             adv;
   logic             lfsr_fb;
   logic             wrap_ok;

   lab3_step_div #(
      .DIV_W    (DIV_W)
   ) u_step_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .clr      (load),
      .step_div (step_div),
      .adv      (adv)
   );

   assign lfsr_fb = ^(q & TAPS);

   always_comb begin
      q_nxt   = q;
      dir_nxt = dir;
      wrap_ok = 1'b1;
      case (mode_t'(mode))
         MODE_HOLD: begin
            wrap_ok = 1'b0;
         end
         MODE_TOGGLE: begin
            q_nxt = ~q;
         end
         MODE_ROTL: begin
            q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
         end
         MODE_ROTR: begin
            q_nxt = {q[0], q[WIDTH-1:1]};
         end
         MODE_LFSR: begin
            // all-zero is the LFSR's dead state; kick it back to 1
            q_nxt = (q == '0) ? ONE : {q[WIDTH-2:0], lfsr_fb};
         end
         MODE_COUNT: begin
            q_nxt = q + ONE;
         end
         MODE_PINGPONG: begin
            if (dir == DIR_LEFT) begin
               if (q[WIDTH-1]) begin
                  dir_nxt = DIR_RIGHT;
                  q_nxt   = q >> 1;
               end else begin
                  q_nxt   = q << 1;
               end
            end else begin
               if (q[0]) begin
                  dir_nxt = DIR_LEFT;
                  q_nxt   = q << 1;
               end else begin
                  q_nxt   = q >> 1;
               end
            end
         end
         default: begin
            wrap_ok = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q    <= INIT;
         seed <= INIT;
         dir  <= DIR_LEFT;
         step <= 1'b0;
         wrap <= 1'b0;
      end else if (load) begin
         q    <= load_data;
         seed <= load_data;
         dir  <= DIR_LEFT;
         step <= 1'b0;
         wrap <= 1'b0;
      end else if (adv) begin
         q    <= q_nxt;
         dir  <= dir_nxt;
         step <= 1'b1;
         wrap <= wrap_ok && (q_nxt == seed);
      end else begin
         step <= 1'b0;
         wrap <= 1'b0;
      end
   end

endmodule
